tile_board: RTL

Parametrised memory-game board controller. Holds the state of `NUM_TILES` tiles and accepts cursor/select input from the player front-end. It reveals picked tiles, compares each pair of labels, and either locks the pair as matched or hides both tiles again after a display delay. It also keeps two-player turn and score and flags game over, replacing per-tile instances that have no pair comparison.

---
 rtl/board_pkg.sv | 23 ++
 rtl/tile_cell.sv | 33 +++
 rtl/tile_board.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared tile codes and FSM state type for the memory-game board.
package board_pkg;

    typedef enum logic [1:0] {
        HIDDEN   = 2'b00,
        REVEALED = 2'b01,
        MATCHED  = 2'b10,
        CURSOR   = 2'b11
    } tile_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ONE_UP,
        S_COMPARE,
        S_SHOW_MISS,
        S_DONE
    } board_fsm_t;

    localparam logic [1:0] CODE_HIDDEN   = 2'b00;
    localparam logic [1:0] CODE_REVEALED = 2'b01;
    localparam logic [1:0] CODE_MATCHED  = 2'b10;

endpackage

// File: rtl/tile_cell.sv
// One board tile: 2-bit state register driven by FSM strobes, plus cursor overlay.
module tile_cell
    import board_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        reveal_i,
    input  logic        hide_i,
    input  logic        match_i,
    input  logic        cursor_hit_i,
    output tile_state_t state_o,
    output tile_state_t disp_o
);

    tile_state_t state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HIDDEN;
        end else if (match_i) begin
            state_q <= MATCHED;
        end else if (hide_i) begin
            state_q <= HIDDEN;
        end else if (reveal_i) begin
            state_q <= REVEALED;
        end
    end

    assign state_o = state_q;
    // Cursor highlight only ever covers a face-down tile.
    assign disp_o  = (state_q == HIDDEN && cursor_hit_i) ? CURSOR : state_q;

endmodule

// File: rtl/tile_board.sv
// Memory-game board controller: pick/compare FSM, miss delay, score and turn.
// Define TILE_BOARD_SCORE_EN for two-player turn/score; otherwise score0 counts all pairs.
module tile_board
    import board_pkg::*;
#(
    parameter  int NUM_TILES  = 16,
    parameter  int LABEL_W    = 4,
    parameter  int HIDE_DELAY = 4,
    localparam int IDX_W      = $clog2(NUM_TILES),
    localparam int SCORE_W    = $clog2(NUM_TILES/2+1)
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             cursor,
    input  logic                         select,
    input  logic [NUM_TILES*LABEL_W-1:0] labels,
    output logic [2*NUM_TILES-1:0]       tile_state,
    output logic [SCORE_W-1:0]           score0,
    output logic [SCORE_W-1:0]           score1,
    output logic                         turn,
    output logic                         busy,
    output logic                         game_over
);

    localparam int                 CNT_W    = (HIDE_DELAY > 1) ? $clog2(HIDE_DELAY) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(HIDE_DELAY-1);
    localparam logic [SCORE_W-1:0] PAIRS    = SCORE_W'(NUM_TILES/2);
    localparam logic [IDX_W:0]     TILES_W  = (IDX_W+1)'(NUM_TILES);

    board_fsm_t         state_q;
    logic [IDX_W-1:0]   first_q, second_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SCORE_W-1:0] score0_q, score1_q, pairs_q, pairs_d;
    logic               turn_q, busy_q, over_q;

    tile_state_t        cell_st   [NUM_TILES];
    tile_state_t        cell_disp [NUM_TILES];
    logic [LABEL_W-1:0] lbl       [NUM_TILES];

    logic in_range, cur_hidden, sel_ok, labels_eq, do_match, do_hide;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == PAIRS) ? v : v + 1'b1;
    endfunction

    assign in_range   = {1'b0, cursor} < TILES_W;
    assign cur_hidden = in_range && (cell_st[cursor] == HIDDEN);
    assign sel_ok     = select && (state_q == S_IDLE || state_q == S_ONE_UP) && cur_hidden;
    assign labels_eq  = (lbl[first_q] == lbl[second_q]);
    assign do_match   = (state_q == S_COMPARE) && labels_eq;
    assign do_hide    = (state_q == S_SHOW_MISS) && (cnt_q == '0);
    assign pairs_d    = pairs_q + 1'b1;

    for (genvar i = 0; i < NUM_TILES; i++) begin : g_tile
        logic is_pair, is_cur;
        assign lbl[i]  = labels[i*LABEL_W +: LABEL_W];
        assign is_cur  = (cursor == IDX_W'(i));
        assign is_pair = (first_q == IDX_W'(i)) || (second_q == IDX_W'(i));

        tile_cell u_cell (
            .clk          (clk),
            .rst          (rst),
            .reveal_i     (sel_ok && is_cur),
            .hide_i       (do_hide && is_pair),
            .match_i      (do_match && is_pair),
            .cursor_hit_i (is_cur),
            .state_o      (cell_st[i]),
            .disp_o       (cell_disp[i])
        );

        assign tile_state[2*i +: 2] = cell_disp[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            first_q  <= '0;
            second_q <= '0;
            cnt_q    <= '0;
            score0_q <= '0;
            score1_q <= '0;
            pairs_q  <= '0;
            turn_q   <= 1'b0;
            busy_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (sel_ok) begin
                        first_q <= cursor;
                        state_q <= S_ONE_UP;
                    end
                end
                S_ONE_UP: begin
                    // The first tile is REVEALED, so sel_ok already excludes re-picking it.
                    if (sel_ok) begin
                        second_q <= cursor;
                        busy_q   <= 1'b1;
                        state_q  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (labels_eq) begin
                        busy_q  <= 1'b0;
                        pairs_q <= pairs_d;
`ifdef TILE_BOARD_SCORE_EN
                        if (turn_q) score1_q <= sat_inc(score1_q);
                        else        score0_q <= sat_inc(score0_q);
`else
                        score0_q <= sat_inc(score0_q);
`endif
                        if (pairs_d == PAIRS) begin
                            over_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= S_SHOW_MISS;
                    end
                end
                S_SHOW_MISS: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`ifdef TILE_BOARD_SCORE_EN
                        turn_q  <= ~turn_q;
`endif
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign score0    = score0_q;
    assign score1    = score1_q;
    assign turn      = turn_q;
    assign busy      = busy_q;
    assign game_over = over_q;

endmodule
